fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request in flight, buffers two instructions for decode.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating perf_fetched / perf_killed counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSN = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] new_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] pcp2_out,
  output logic [15:0] ir_out,
  output logic        valid_out
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_killed
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL} state_t;

  state_t      state;
  logic [15:0] fpc;
  logic        pending;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [15:0] q_pc [2];
  logic [15:0] q_ir [2];

  logic        ack_seen;
  logic        ack_take;
  logic        ack_drop;
  logic        push;
  logic        pop;
  logic [15:0] jump_pc;

  // pending = request raised in an earlier cycle and still waiting for its ack;
  // it keeps imem_req high even if the queue filled behind it.
  always_comb begin
    imem_req  = (state == S_REQ) && (pending || (count < 2'd2));
    ack_seen  = imem_ack && (imem_req || (state == S_KILL));
    ack_take  = ack_seen && (state == S_REQ) && !jump;
    ack_drop  = ack_seen && !ack_take;
    push      = ack_take;
    valid_out = (count != 2'd0);
    pop       = valid_out && !stall && !jump;
    jump_pc   = new_pc & 16'hFFFE;
  end

  assign imem_addr = fpc;

  always_comb begin
    if (valid_out) begin
      pc_out   = q_pc[rd_ptr];
      pcp2_out = q_pc[rd_ptr] + 16'd2;
      ir_out   = q_ir[rd_ptr];
    end else begin
      pc_out   = '0;
      pcp2_out = '0;
      ir_out   = NOP_INSN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every block samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      fpc     <= RESET_PC;
      pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_REQ;
        S_REQ:   if (jump && imem_req && !imem_ack) state <= S_KILL;
        S_KILL:  if (imem_ack) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
      pending <= (state == S_REQ) && imem_req && !imem_ack && !jump;
      if (jump)          fpc <= jump_pc;
      else if (ack_take) fpc <= fpc + 16'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (jump) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: queue storage is not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= fpc;
      q_ir[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (ack_take && (perf_fetched != 16'hFFFF)) perf_fetched <= perf_fetched + 16'd1;
      if (ack_drop && (perf_killed != 16'hFFFF))  perf_killed  <= perf_killed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing checks plus randomized stall/jump traffic against a PC-stream scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, jump;
  logic [15:0] new_pc;
  logic        imem_req, imem_ack, valid_out;
  logic [15:0] imem_addr, imem_rdata, pc_out, pcp2_out, ir_out;
  logic        req2, ack2, valid2;
  logic [15:0] addr2, rdata2, pc2, pcp22, ir2;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] perf_fetched, perf_killed, perf2_f, perf2_k;
`endif

  int errors = 0;
  int checks = 0;
  int consumed = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .pcp2_out(pcp2_out), .ir_out(ir_out), .valid_out(valid_out)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .reset(reset), .stall(1'b0), .jump(1'b0), .new_pc(16'h0000),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .pc_out(pc2), .pcp2_out(pcp22), .ir_out(ir2), .valid_out(valid2)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf2_f), .perf_killed(perf2_k)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with programmable latency; it latches the address on the cycle a request starts.
  int          mem_lat;
  logic        busy;
  int          cnt;
  logic [15:0] addr_l;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end else if (imem_req && mem_lat > 0) begin
      busy   <= 1'b1;
      cnt    <= mem_lat - 1;
      addr_l <= imem_addr;
    end
  end

  assign imem_ack   = busy ? (cnt == 0) : (imem_req && mem_lat == 0);
  assign imem_rdata = mem_word(busy ? addr_l : imem_addr);
  assign ack2       = req2;
  assign rdata2     = mem_word(addr2);

  // Expected architectural stream: consecutive PCs from the last reset/redirect target.
  logic [15:0] exp_q [$];
  logic [15:0] sb_e;

  task automatic sb_restart(input logic [15:0] pc);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(pc + 16'(2 * k));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out && !stall && !jump) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected nothing", pc_out);
        end else begin
          sb_e = exp_q.pop_front();
          exp_q.push_back(sb_e + 16'd16);
          check("sb_pc", pc_out, sb_e);
          check("sb_pcp2", pcp2_out, sb_e + 16'd2);
          check("sb_ir", ir_out, mem_word(sb_e));
          consumed++;
        end
      end else if (!valid_out) begin
        check("nop_ir", ir_out, 16'h0000);
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb_restart(16'h0000);
  endtask

  task automatic do_reset(input int lat);
    reset   = 1'b1;
    stall   = 1'b0;
    jump    = 1'b0;
    mem_lat = lat;
    release_reset();
  endtask

  task automatic do_jump(input logic [15:0] pc);
    jump   = 1'b1;
    new_pc = pc;
    @(posedge clk);
    #1;
    jump = 1'b0;
    sb_restart(pc & 16'hFFFE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    bit jv;
    logic [15:0] jpc;

    reset = 1'b1; stall = 1'b0; jump = 1'b0; new_pc = '0; mem_lat = 0;
    #12;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", valid_out, 0);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_pcp2", pcp2_out, 16'h0000);
    check("rst_addr2", addr2, 16'hFFFC);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_perf_f", perf_fetched, 0);
    check("rst_perf_k", perf_killed, 0);
`endif

    // Zero-wait streaming from reset, with the wrapping instance alongside.
    release_reset();
    step();
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 16'h0000);
    check("c1_valid", valid_out, 0);
    step();
    check("c2_valid", valid_out, 1);
    check("c2_pc", pc_out, 16'h0000);
    check("c2_pcp2", pcp2_out, 16'h0002);
    check("c2_ir", ir_out, 16'h1000);
    check("c2_addr", imem_addr, 16'h0002);
    check("w_pc0", pc2, 16'hFFFC);
    step();
    check("c3_pc", pc_out, 16'h0002);
    check("w_pc1", pc2, 16'hFFFE);
    check("w_pcp2", pcp22, 16'h0000);
    check("w_ir", ir2, 16'h0FFE);
    step();
    check("c4_pc", pc_out, 16'h0004);
    check("w_pc2", pc2, 16'h0000);

    // Stall for five cycles with pc 4 at the head.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_pc", pc_out, 16'h0004);
      check("st_ir", ir_out, 16'h1004);
      check("st_valid", valid_out, 1);
      check("st_req", imem_req, 0);
      check("st_addr", imem_addr, 16'h0008);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("st_perf_f", perf_fetched, 16'd4);
`endif
    stall = 1'b0;
    check("rel_pc0", pc_out, 16'h0004);
    step();
    check("rel_pc1", pc_out, 16'h0006);
    step();
    check("rel_pc2", pc_out, 16'h0008);

    // Redirect while stalled with a full queue.
    stall = 1'b1;
    step();
    step();
    check("full_req", imem_req, 0);
    check("full_pc", pc_out, 16'h0008);
    do_jump(16'h0101);
    check("js_valid", valid_out, 0);
    check("js_req", imem_req, 1);
    check("js_addr", imem_addr, 16'h0100);
    stall = 1'b0;
    step();
    check("js_valid2", valid_out, 1);
    check("js_pc", pc_out, 16'h0100);
    check("js_ir", ir_out, 16'h1100);

    // 3-cycle memory: kill the in-flight fetch of 0x0008.
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0008) found = 1'b1;
    end
    check("k_found", 16'(found), 16'd1);
    do_jump(16'h0041);
    check("k_req", imem_req, 0);
    check("k_valid", valid_out, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("k_perf_f", perf_fetched, 16'd4);
`endif
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem_req) found = 1'b1;
    end
    check("k_req_seen", 16'(found), 16'd1);
    check("k_addr", imem_addr, 16'h0040);
`ifdef FETCH_PERF_COUNTERS_EN
    check("k_perf_k", perf_killed, 16'd1);
`endif
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (valid_out) found = 1'b1;
    end
    check("k_valid_seen", 16'(found), 16'd1);
    check("k_pc", pc_out, 16'h0040);
    check("k_ir", ir_out, 16'h1040);

    // Asynchronous reset while a request waits on the slow memory.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_req && !imem_ack && valid_out) found = 1'b1;
    end
    check("ar_found", 16'(found), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_req", imem_req, 0);
    check("ar_valid", valid_out, 0);
    check("ar_ir", ir_out, 16'h0000);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (imem_req) found = 1'b1;
    end
    check("ar_req_seen", 16'(found), 16'd1);
    check("ar_addr", imem_addr, 16'h0000);

    // Randomized stall/redirect traffic over several memory latencies.
    consumed = 0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(int'($urandom_range(0, 3)));
      for (int c = 0; c < 400; c++) begin
        jv  = ($urandom_range(0, 99) < 4);
        jpc = 16'($urandom);
        stall  = ($urandom_range(0, 99) < 30);
        jump   = jv;
        new_pc = jpc;
        step();
        if (jv) begin
          jump = 1'b0;
          sb_restart(jpc & 16'hFFFE);
        end
      end
    end
    stall = 1'b0;
    jump  = 1'b0;
    step();
    check("progress", 16'(consumed > 200), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
